// File: rtl/aes_engine_scheduler.sv
// Round-robin front end sharing one byte-serial aes_engine between two requesters.
// Define AES_SCHED_TIMEOUT_EN to abort jobs that sit in START longer than TIMEOUT_CYCLES.
module aes_engine_scheduler #(
    parameter int unsigned IDLE_GAP       = 5,
    parameter int unsigned READ_HOLD      = 5,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic         clk,
    input  logic         rst_,
    input  logic [1:0]   req_valid,
    output logic [1:0]   req_ready,
    input  logic [127:0] req_pt0,
    input  logic [127:0] req_key0,
    input  logic [127:0] req_pt1,
    input  logic [127:0] req_key1,
    output logic [1:0]   done,
    output logic [1:0]   err,
    output logic         busy,
    output logic [7:0]   eng_din,
    output logic [1:0]   eng_cmd,
    output logic         eng_output_read,
    input  logic         eng_interface_ready,
    input  logic         eng_engine_done
);
    localparam int unsigned CW = 8;
    localparam logic [1:0] C_ID = 2'b00;
    localparam logic [1:0] C_SP = 2'b01;
    localparam logic [1:0] C_SK = 2'b10;
    localparam logic [1:0] C_ST = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_PT,
        S_LOAD_KEY,
        S_START,
        S_GAP,
        S_READ
    } state_t;

    state_t        state, state_n;
    logic [3:0]    byte_cnt, byte_cnt_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [127:0]  pt_reg, pt_n;
    logic [127:0]  key_reg, key_n;
    logic          grant, grant_n;
    logic          last_grant, last_grant_n;
    logic          done_d;
    logic [1:0]    done_n;
    logic          pref, gnt_valid, gnt_idx;
    logic          done_rise;
    logic [1:0]    grant_oh;

`ifdef AES_SCHED_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_cnt, tmo_cnt_n;
    logic [1:0]    err_n;
`else
    logic [31:0]   unused_tmo;
    assign unused_tmo = 32'(TIMEOUT_CYCLES);
    assign err        = 2'b00;
`endif

    assign done_rise = eng_engine_done & ~done_d;
    assign grant_oh  = grant ? 2'b10 : 2'b01;

    // Round-robin pick: the requester that did not win last time has priority.
    always_comb begin
        pref      = ~last_grant;
        gnt_valid = 1'b0;
        gnt_idx   = pref;
        if (state == S_IDLE && !rst_) begin
            if (req_valid[pref]) begin
                gnt_valid = 1'b1;
                gnt_idx   = pref;
            end else if (req_valid[last_grant]) begin
                gnt_valid = 1'b1;
                gnt_idx   = last_grant;
            end
        end
        req_ready = {gnt_valid & gnt_idx, gnt_valid & ~gnt_idx};
    end

    always_comb begin
        state_n      = state;
        byte_cnt_n   = byte_cnt;
        cnt_n        = cnt;
        pt_n         = pt_reg;
        key_n        = key_reg;
        grant_n      = grant;
        last_grant_n = last_grant;
        done_n       = 2'b00;
`ifdef AES_SCHED_TIMEOUT_EN
        tmo_cnt_n    = tmo_cnt;
        err_n        = 2'b00;
`endif
        case (state)
            S_IDLE: begin
                if (gnt_valid) begin
                    pt_n       = gnt_idx ? req_pt1 : req_pt0;
                    key_n      = gnt_idx ? req_key1 : req_key0;
                    grant_n    = gnt_idx;
                    byte_cnt_n = 4'd0;
                    state_n    = S_LOAD_PT;
                end
            end
            // Byte registers shift out MSB-first; the counter only tracks the phase end.
            S_LOAD_PT: begin
                if (eng_interface_ready) begin
                    pt_n       = {pt_reg[119:0], 8'h00};
                    byte_cnt_n = byte_cnt + 4'd1;
                    if (byte_cnt == 4'd15) state_n = S_LOAD_KEY;
                end
            end
            S_LOAD_KEY: begin
                if (eng_interface_ready) begin
                    key_n      = {key_reg[119:0], 8'h00};
                    byte_cnt_n = byte_cnt + 4'd1;
                    if (byte_cnt == 4'd15) begin
                        state_n = S_START;
`ifdef AES_SCHED_TIMEOUT_EN
                        tmo_cnt_n = '0;
`endif
                    end
                end
            end
            S_START: begin
                if (done_rise) begin
                    cnt_n   = '0;
                    state_n = S_GAP;
                end
`ifdef AES_SCHED_TIMEOUT_EN
                else if (tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                    err_n        = grant_oh;
                    last_grant_n = grant;
                    state_n      = S_IDLE;
                end else begin
                    tmo_cnt_n = tmo_cnt + TW'(1);
                end
`endif
            end
            S_GAP: begin
                if (cnt == CW'(IDLE_GAP - 1)) begin
                    cnt_n   = '0;
                    state_n = S_READ;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            S_READ: begin
                if (cnt == CW'(READ_HOLD - 1)) begin
                    cnt_n        = '0;
                    done_n       = grant_oh;
                    last_grant_n = grant;
                    state_n      = S_IDLE;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Engine-side outputs decode straight from the state register.
    always_comb begin
        eng_cmd         = C_ID;
        eng_din         = 8'h00;
        eng_output_read = 1'b0;
        busy            = (state != S_IDLE);
        case (state)
            S_LOAD_PT: begin
                eng_cmd = C_SP;
                eng_din = pt_reg[127:120];
            end
            S_LOAD_KEY: begin
                eng_cmd = C_SK;
                eng_din = key_reg[127:120];
            end
            S_START: eng_cmd = C_ST;
            S_READ:  eng_output_read = 1'b1;
            default: eng_cmd = C_ID;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_) begin
            state      <= S_IDLE;
            byte_cnt   <= 4'd0;
            cnt        <= '0;
            pt_reg     <= '0;
            key_reg    <= '0;
            grant      <= 1'b0;
            last_grant <= 1'b1;
            done_d     <= 1'b0;
            done       <= 2'b00;
`ifdef AES_SCHED_TIMEOUT_EN
            tmo_cnt    <= '0;
            err        <= 2'b00;
`endif
        end else begin
            state      <= state_n;
            byte_cnt   <= byte_cnt_n;
            cnt        <= cnt_n;
            pt_reg     <= pt_n;
            key_reg    <= key_n;
            grant      <= grant_n;
            last_grant <= last_grant_n;
            done_d     <= eng_engine_done;
            done       <= done_n;
`ifdef AES_SCHED_TIMEOUT_EN
            tmo_cnt    <= tmo_cnt_n;
            err        <= err_n;
`endif
        end
    end
endmodule

// File: tb/tb_aes_engine_scheduler.sv
// Directed bench for aes_engine_scheduler: job table plus mid-job reset sequence.
// Timeout vectors are added when AES_SCHED_TIMEOUT_EN is defined.
module tb_aes_engine_scheduler;
    localparam int unsigned GAP  = 5;
    localparam int unsigned HOLD = 5;
    localparam int unsigned TMO  = 16;
    localparam int          LAT  = 20;
    localparam logic [127:0] PT0  = 128'h00041214120412000C00131108231919;
    localparam logic [127:0] KEY0 = 128'h2475A2B33475568831E2120013AA5487;
    localparam logic [127:0] PT1  = 128'h00112233445566778899AABBCCDDEEFF;
    localparam logic [127:0] KEY1 = 128'h000102030405060708090A0B0C0D0E0F;

    logic         clk = 1'b0;
    logic         rst_ = 1'b1;
    logic [1:0]   req_valid = 2'b00;
    logic [1:0]   req_ready;
    logic [127:0] req_pt0 = PT0, req_key0 = KEY0, req_pt1 = PT1, req_key1 = KEY1;
    logic [1:0]   done, err;
    logic         busy;
    logic [7:0]   eng_din;
    logic [1:0]   eng_cmd;
    logic         eng_output_read;
    logic         eng_interface_ready = 1'b1;
    logic         eng_engine_done;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    aes_engine_scheduler #(
        .IDLE_GAP(GAP),
        .READ_HOLD(HOLD),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk),
        .rst_(rst_),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_pt0(req_pt0),
        .req_key0(req_key0),
        .req_pt1(req_pt1),
        .req_key1(req_key1),
        .done(done),
        .err(err),
        .busy(busy),
        .eng_din(eng_din),
        .eng_cmd(eng_cmd),
        .eng_output_read(eng_output_read),
        .eng_interface_ready(eng_interface_ready),
        .eng_engine_done(eng_engine_done)
    );

    // Behavioural engine: done visible LAT-1 cycles after the first C_ST cycle.
    int   st_cnt = 0;
    logic model_done = 1'b0;
    logic eng_manual = 1'b0;
    logic man_done = 1'b0;
    always @(posedge clk) begin
        if (eng_cmd == 2'b11) begin
            st_cnt     <= st_cnt + 1;
            model_done <= (st_cnt + 1 >= LAT - 1);
        end else begin
            st_cnt     <= 0;
            model_done <= 1'b0;
        end
    end
    assign eng_engine_done = eng_manual ? man_done : model_done;

    typedef struct {
        logic [1:0]   valid;
        logic [127:0] stall;
        bit           hold;
        bit           manual;
        int           fall;
        int           rise;
        logic [1:0]   exp_ready;
        int           exp_st;
        int           exp_end;
        logic [1:0]   exp_done;
        logic [1:0]   exp_err;
        int           exp_reads;
    } vec_t;

    function automatic vec_t mk(input logic [1:0] valid, input logic [127:0] stall,
                                input bit hold, input bit manual, input int fall, input int rise,
                                input logic [1:0] er, input int st, input int e,
                                input logic [1:0] ed, input logic [1:0] ee, input int reads);
        vec_t v;
        v.valid = valid; v.stall = stall; v.hold = hold; v.manual = manual;
        v.fall = fall; v.rise = rise; v.exp_ready = er; v.exp_st = st;
        v.exp_end = e; v.exp_done = ed; v.exp_err = ee; v.exp_reads = reads;
        return v;
    endfunction

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Runs one job starting at the current cycle (cycle 0 = grant cycle).
    task automatic run_job(input vec_t v, input int idx);
        logic [255:0] expv;
        logic [7:0]   cap [32];
        logic [1:0]   capc [32];
        int ncap = 0, st = -1, reads = 0, rfirst = -1, busyc = 0, endc = -1, bad = 0;
        logic [1:0] rdy = 2'b00, dv = 2'b00, ev = 2'b00;
        eng_manual = v.manual;
        for (int k = 0; k < 300; k++) begin
            if (k > 0) begin
                @(posedge clk);
                #1;
            end
            eng_interface_ready = (k < 128) ? ~v.stall[k] : 1'b1;
            if (k == 0) begin
                req_valid = v.valid;
                req_pt0 = PT0; req_key0 = KEY0; req_pt1 = PT1; req_key1 = KEY1;
            end else begin
                if (!v.hold) req_valid = 2'b00;
                req_pt0 = ~PT0; req_key0 = ~KEY0; req_pt1 = ~PT1; req_key1 = ~KEY1;
            end
            man_done = (k < v.fall) || (k >= v.rise);
            #1;
            if (k == 0) rdy = req_ready;
            if (k > 0 && (done != 2'b00 || err != 2'b00)) begin
                endc = k; dv = done; ev = err;
                break;
            end
            if (busy) busyc++;
            if ((eng_cmd == 2'b01 || eng_cmd == 2'b10) && eng_interface_ready && ncap < 32) begin
                cap[ncap] = eng_din; capc[ncap] = eng_cmd; ncap++;
            end
            if (eng_cmd == 2'b11 && st < 0) st = k;
            if (eng_output_read) begin
                reads++;
                if (rfirst < 0) rfirst = k;
            end
        end
        expv = v.exp_ready[1] ? {PT1, KEY1} : {PT0, KEY0};
        for (int i = 0; i < 32; i++)
            if (cap[i] !== expv[255-8*i -: 8] || capc[i] !== ((i < 16) ? 2'b01 : 2'b10)) bad++;
        chk($sformatf("v%0d_req_ready", idx), rdy, v.exp_ready);
        chk($sformatf("v%0d_byte_count", idx), ncap, 32);
        chk($sformatf("v%0d_bad_bytes", idx), bad, 0);
        chk($sformatf("v%0d_first_start", idx), st, v.exp_st);
        chk($sformatf("v%0d_end_cycle", idx), endc, v.exp_end);
        chk($sformatf("v%0d_done", idx), dv, v.exp_done);
        chk($sformatf("v%0d_err", idx), ev, v.exp_err);
        chk($sformatf("v%0d_reads", idx), reads, v.exp_reads);
        chk($sformatf("v%0d_busy_cycles", idx), busyc, v.exp_end - 1);
        if (v.exp_reads > 0)
            chk($sformatf("v%0d_read_first", idx), rfirst, v.exp_end - int'(HOLD));
    endtask

    vec_t tbl [10];
    int   n_vec;
    logic [127:0] bp;
    logic [127:0] kv;
    logic [1:0]   seen;
    vec_t rv;

    initial begin
        bp = '0;
        bp[3] = 1'b1; bp[4] = 1'b1; bp[5] = 1'b1; bp[20] = 1'b1;
        tbl[0] = mk(2'b01, '0, 1'b0, 1'b0, 0, 0,      2'b01, 33, 63, 2'b01, 2'b00, 5);
        tbl[1] = mk(2'b01, bp, 1'b0, 1'b0, 0, 0,      2'b01, 37, 67, 2'b01, 2'b00, 5);
        tbl[2] = mk(2'b10, '0, 1'b0, 1'b1, 40, 45,    2'b10, 33, 56, 2'b10, 2'b00, 5);
        tbl[3] = mk(2'b11, '0, 1'b1, 1'b0, 0, 0,      2'b01, 33, 63, 2'b01, 2'b00, 5);
        tbl[4] = mk(2'b11, '0, 1'b1, 1'b0, 0, 0,      2'b10, 33, 63, 2'b10, 2'b00, 5);
        tbl[5] = mk(2'b11, '0, 1'b1, 1'b0, 0, 0,      2'b01, 33, 63, 2'b01, 2'b00, 5);
        tbl[6] = mk(2'b11, '0, 1'b0, 1'b0, 0, 0,      2'b10, 33, 63, 2'b10, 2'b00, 5);
        n_vec = 7;
`ifdef AES_SCHED_TIMEOUT_EN
        tbl[7] = mk(2'b11, '0, 1'b1, 1'b1, 0, 100000, 2'b01, 33, 33 + int'(TMO), 2'b00, 2'b01, 0);
        tbl[8] = mk(2'b11, '0, 1'b0, 1'b0, 0, 0,      2'b10, 33, 63, 2'b10, 2'b00, 5);
        n_vec = 9;
`endif

        // Reset state, with both requesters asserting valid.
        repeat (3) @(posedge clk);
        #1 req_valid = 2'b11;
        #1;
        chk("rst_req_ready", req_ready, 2'b00);
        chk("rst_eng_cmd", eng_cmd, 2'b00);
        chk("rst_eng_din", eng_din, 8'h00);
        chk("rst_output_read", eng_output_read, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 2'b00);
        chk("rst_err", err, 2'b00);
        req_valid = 2'b00;
        rst_ = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < n_vec; i++) begin
            run_job(tbl[i], i);
            if (!tbl[i].hold) req_valid = 2'b00;
        end
        eng_manual = 1'b0;

        // Reset in the middle of LOAD_KEY byte 7 of a requester-1 job.
        req_valid = 2'b10;
        req_pt0 = PT0; req_key0 = KEY0; req_pt1 = PT1; req_key1 = KEY1;
        eng_interface_ready = 1'b1;
        #1;
        chk("mid_rst_grant", req_ready, 2'b10);
        for (int k = 1; k <= 24; k++) begin
            @(posedge clk);
            #1 req_valid = 2'b00;
            #1;
        end
        kv = KEY1;
        chk("mid_rst_cmd_before", eng_cmd, 2'b10);
        chk("mid_rst_din_before", eng_din, kv[71:64]);
        rst_ = 1'b1;
        @(posedge clk);
        #2;
        chk("mid_rst_cmd_after", eng_cmd, 2'b00);
        chk("mid_rst_busy_after", busy, 1'b0);
        chk("mid_rst_din_after", eng_din, 8'h00);
        seen = done | err;
        rst_ = 1'b0;
        repeat (5) begin
            @(posedge clk);
            #2 seen = seen | done | err;
        end
        chk("mid_rst_no_pulse", seen, 2'b00);

        rv = mk(2'b11, '0, 1'b0, 1'b0, 0, 0, 2'b01, 33, 63, 2'b01, 2'b00, 5);
        run_job(rv, 99);
        req_valid = 2'b00;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/aes_engine_scheduler.md
Name: aes_engine_scheduler

Overview:
Front-end controller that shares one byte-serial aes_engine between two requesters. Round-robin arbitration picks a requester and latches its 128-bit plaintext and key. The block then serializes them into the engine's cmd/din interface as 16 C_SP bytes, 16 C_SK bytes and C_ST. It waits for engine_done, performs the output-read handshake and reports completion to the granted requester.

Parameters:
IDLE_GAP, 5, cycles of C_ID driven after engine_done before asserting output_read (1..255)
READ_HOLD, 5, cycles output_read is held high (1..255)
TIMEOUT_CYCLES, 1024, max cycles in START awaiting engine_done (only with AES_SCHED_TIMEOUT_EN)

Ports:
clk  in  1  system clock, rising edge
rst_  in  1  synchronous, active-high reset
req_valid  in  2  bit n: requester n has a job pending
req_ready  out  2  bit n: job n accepted this cycle (one-hot or zero)
req_pt0  in  128  requester 0 plaintext; byte 0 = [127:120]
req_key0  in  128  requester 0 key
req_pt1  in  128  requester 1 plaintext
req_key1  in  128  requester 1 key
done  out  2  one-cycle completion pulse to requester n
err  out  2  one-cycle timeout pulse to requester n
busy  out  1  high whenever state != IDLE
eng_din  out  8  byte to engine
eng_cmd  out  2  00 C_ID, 01 C_SP, 10 C_SK, 11 C_ST
eng_output_read  out  1  output-read strobe to engine
eng_interface_ready  in  1  engine accepts a din byte this cycle
eng_engine_done  in  1  engine result available

Behaviour:
- Reset: state IDLE, byte_cnt 0, last_grant 1 (requester 0 wins first), eng_cmd C_ID, eng_din 0, eng_output_read 0, done/err/req_ready 0, busy 0. Reset mid-job aborts silently with no done/err pulse.
- eng_cmd, eng_din, eng_output_read and busy decode from state/counter registers (Moore).
- req_ready is combinational: in IDLE, grant = requester != last_grant if it is valid, else the other if valid.
- IDLE: on a grant, latch pt/key into internal regs, record g, byte_cnt 0, next LOAD_PT. Requesters may drop valid or change data after the ready cycle.
- LOAD_PT: eng_cmd C_SP, eng_din = pt_reg byte byte_cnt (MSB byte first).
  - byte_cnt increments only on cycles with eng_interface_ready=1; otherwise byte and cmd hold.
  - Ready at byte_cnt 15 -> LOAD_KEY with byte_cnt 0.
- LOAD_KEY: same as LOAD_PT with C_SK and key_reg; at byte 15 accepted -> START.
- START: eng_cmd C_ST, eng_din 0.
  - Leave only on a rising edge of eng_engine_done, using a registered done_d. A level already high on entry is ignored.
  - interface_ready is ignored here.
  - Rising edge -> GAP with cnt 0.
- GAP: eng_cmd C_ID for IDLE_GAP cycles -> READ.
- READ: eng_cmd C_ID, eng_output_read 1 for READ_HOLD cycles -> IDLE. last_grant = g.
- done[g] is a registered pulse in the first IDLE cycle after READ; a new grant may occur in that same cycle.
- Throughput with interface_ready constantly 1 and engine latency L cycles from first C_ST cycle:
  - grant cycle 0, first C_SP cycle 1, last C_SK cycle 32, C_ST from cycle 33;
  - done pulse at 33+L+IDLE_GAP+READ_HOLD.
- Both valid in IDLE: alternate strictly. A single requester may be granted back-to-back.

Optional Feature:
AES_SCHED_TIMEOUT_EN:
- Defined: a counter runs in START. If TIMEOUT_CYCLES elapse without a done rising edge:
  - err[g] pulses one cycle;
  - eng_cmd returns to C_ID;
  - no output_read, no done;
  - state -> IDLE, last_grant = g.
- Undefined: START waits indefinitely; err tied 0; no counter logic synthesized.

Test Plan:
- Single job: req_valid=01, pt=00041214120412000C00131108231919, key=2475A2B334755688 31E2120013AA5487, ready=1 -> req_ready=01 at cycle 0. eng_din 00,04,12,... under C_SP, then 24,75,A2,... under C_SK, then C_ST. Behavioural engine done after 20 cycles -> output_read high 5 cycles after 5-cycle gap; done=01 at cycle 63.
- Backpressure: same job, interface_ready low on cycles 3-5 and 20 -> bytes held, no byte skipped or duplicated; 32 bytes captured equal pt||key; done delayed by exactly 4 cycles.
- Arbitration: req_valid=11 held -> grants 0,1,0,1. Requester 1 data appears on eng_din for jobs 2 and 4. No overlapping busy periods.
- Stale done: engine_done held high from a prior job into START -> no exit until it falls and rises again.
- Reset mid-job: rst_=1 during LOAD_KEY byte 7 -> next cycle eng_cmd=00, busy=0, no done/err. Next grant restarts at pt byte 0.
- Timeout (AES_SCHED_TIMEOUT_EN, TIMEOUT_CYCLES=16): engine never signals done -> err=01 pulse after 16 START cycles, output_read never asserted, requester 1 then granted.
